// File: rtl/bw_io_ddr_rd_rcv.sv
// DDR read-return receiver: retimes pad read beats, tags the last beat of
// each DRAM burst, and queues beats in a small return FIFO toward the
// controller. Beats arriving while the FIFO is full (and not draining) are
// dropped and flagged through a sticky overflow bit.
// Optional feature macro: BW_IO_DDR_RD_PARITY_EN adds per-byte even parity
// storage and the ctl_rd_par output.
module bw_io_ddr_rd_rcv #(
    parameter int FIFO_DEPTH = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pad_rd_vld,
    input  logic [31:0] pad_rd_data,
    input  logic        ctl_rd_rdy,
    output logic        ctl_rd_vld,
    output logic [31:0] ctl_rd_data,
    output logic        ctl_rd_last,
    output logic        ovfl_err,
    output logic [4:0]  fifo_cnt
`ifdef BW_IO_DDR_RD_PARITY_EN
    ,
    output logic [3:0]  ctl_rd_par
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (BURST_LEN  > 1) ? $clog2(BURST_LEN)  : 1;
    localparam logic [CW-1:0] BEAT_LAST = CW'(BURST_LEN - 1);
    localparam logic [4:0]    CNT_FULL  = 5'(FIFO_DEPTH);

    // beat position within the current DRAM burst
    logic [CW-1:0] bcnt;
    logic          pad_last;

    // retiming stage
    logic          stg_vld;
    logic [31:0]   stg_data;
    logic          stg_last;

    // return FIFO
    logic [31:0]   mem_data [FIFO_DEPTH];
    logic          mem_last [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

`ifdef BW_IO_DDR_RD_PARITY_EN
    logic [3:0]    stg_par;
    logic [3:0]    mem_par [FIFO_DEPTH];
    logic [3:0]    pad_par;
`endif

    assign pad_last = (bcnt == BEAT_LAST);

    assign full = (fifo_cnt == CNT_FULL);
    assign pop  = ctl_rd_vld & ctl_rd_rdy;
    // a pop frees the slot the full FIFO would otherwise refuse
    assign push = stg_vld & (~full | pop);
    assign drop = stg_vld & full & ~pop;

    assign ctl_rd_vld  = (fifo_cnt != 5'd0);
    assign ctl_rd_data = mem_data[rptr];
    assign ctl_rd_last = mem_last[rptr];

`ifdef BW_IO_DDR_RD_PARITY_EN
    always_comb begin
        pad_par = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            pad_par[b] = ^pad_rd_data[8*b +: 8];
        end
    end
    assign ctl_rd_par = mem_par[rptr];
`endif

    // count every pad beat, dropped ones included, so framing tracks the DRAM
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt <= '0;
        end else if (pad_rd_vld) begin
            bcnt <= pad_last ? '0 : bcnt + 1'b1;
        end
    end

    // retime pad beat together with its computed last tag
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld  <= 1'b0;
            stg_data <= '0;
            stg_last <= 1'b0;
        end else begin
            stg_vld  <= pad_rd_vld;
            stg_data <= pad_rd_data;
            stg_last <= pad_last;
        end
    end

`ifdef BW_IO_DDR_RD_PARITY_EN
    // parity is computed once at the stage and carried with the beat
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_par <= '0;
        end else begin
            stg_par <= pad_par;
        end
    end

    // parity storage alongside each FIFO entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_par[i] <= '0;
            end
        end else if (push) begin
            mem_par[wptr] <= stg_par;
        end
    end
`endif

    // FIFO entry storage; cleared on reset so the head reads 0 until first push
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
        end else if (push) begin
            mem_data[wptr] <= stg_data;
            mem_last[wptr] <= stg_last;
        end
    end

    // pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 5'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 5'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // sticky overflow: set whenever a staged beat is refused
    always_ff @(posedge clk) begin
        if (rst) begin
            ovfl_err <= 1'b0;
        end else if (drop) begin
            ovfl_err <= 1'b1;
        end
    end

endmodule

// File: doc/bw_io_ddr_rd_rcv.md
BW_IO_DDR_RD_RCV -- requirements
Module: bw_io_ddr_rd_rcv

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the number of return FIFO entries; it SHALL be a power of two, 2..16.
REQ-002 Parameter BURST_LEN, default 4, is the number of beats per DRAM read burst; it SHALL be a power of two, 2..8.
REQ-003 clk  input  1  is the single core clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 pad_rd_vld  input  1  SHALL mark a valid read beat arriving from the pad side, with no backpressure.
REQ-006 pad_rd_data  input  32  SHALL carry the read beat payload.
REQ-007 ctl_rd_rdy  input  1  SHALL indicate that the controller accepts a beat this cycle.
REQ-008 ctl_rd_vld  output  1  SHALL indicate that the FIFO head beat is valid.
REQ-009 ctl_rd_data  output  32  SHALL carry the FIFO head payload.
REQ-010 ctl_rd_last  output  1  SHALL mark the head beat as the final beat of its burst.
REQ-011 ovfl_err  output  1  SHALL be a sticky flag indicating that a beat was dropped.
REQ-012 fifo_cnt  output  5  SHALL report the current FIFO occupancy, 0..FIFO_DEPTH.
REQ-013 ctl_rd_par  output  4  SHALL carry the per-byte even parity of the head beat; this port exists only under BW_IO_DDR_RD_PARITY_EN.

Function
REQ-014 The input retiming stage SHALL register pad_rd_vld and pad_rd_data, plus the computed last tag, on every clk edge.
REQ-015 The beat counter SHALL increment on every pad_rd_vld cycle, modulo BURST_LEN.
REQ-016 The last tag SHALL be 1 when the beat counter equals BURST_LEN-1 at the time of the pad beat.
REQ-017 The beat counter SHALL count dropped beats too, so that burst framing stays aligned with the DRAM.
REQ-018 Push SHALL occur when the stage is valid and either the FIFO is not full or a pop occurs in the same cycle.
REQ-019 Pop SHALL occur when ctl_rd_vld and ctl_rd_rdy are both 1.
REQ-020 Latency: a pad beat sampled at edge E SHALL be written at edge E+1, and SHALL be visible on ctl_rd_* after edge E+1 when the FIFO was empty (2 cycles).
REQ-021 There SHALL be no bypass: an empty FIFO with a stage push SHALL NOT present the beat on the same edge.
REQ-022 Full with simultaneous push and pop: both SHALL occur, occupancy SHALL stay at FIFO_DEPTH, and ovfl_err SHALL stay unchanged.
REQ-023 Full with push and no pop: the staged beat SHALL be dropped, FIFO contents SHALL be unchanged, and ovfl_err SHALL be set at the next edge.
REQ-024 Empty with push and pop: no pop SHALL occur, because ctl_rd_vld is 0.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 fifo_cnt SHALL be updated by +1 on push only, -1 on pop only, and 0 on both.
REQ-027 ctl_rd_data, ctl_rd_last and ctl_rd_par SHALL hold stable while ctl_rd_vld=1 and ctl_rd_rdy=0.
REQ-028 ctl_rd_vld SHALL equal (fifo_cnt != 0).
REQ-029 Once set, ovfl_err SHALL remain 1 until rst.

Reset
REQ-030 While rst=1, all of the following SHALL be cleared to 0: stage valid, beat counter, pointers, fifo_cnt, ctl_rd_vld, ovfl_err.
REQ-031 ctl_rd_data, ctl_rd_last and ctl_rd_par SHALL be 0 during and after reset until the first push.
REQ-032 Reset mid-burst SHALL discard all staged and queued beats.
REQ-033 After reset mid-burst, the beat counter SHALL restart at 0, so the next pad beat is beat 0.
REQ-034 pad_rd_vld asserted in a reset cycle SHALL be ignored.

Configuration
REQ-035 With BW_IO_DDR_RD_PARITY_EN defined, each FIFO entry SHALL store 4 parity bits computed at the stage, one XOR per byte.
REQ-036 With BW_IO_DDR_RD_PARITY_EN defined, ctl_rd_par[i] SHALL equal the XOR of ctl_rd_data[8i+7:8i].
REQ-037 Without BW_IO_DDR_RD_PARITY_EN, the ctl_rd_par port and its storage SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 Reset, then one burst of beats 0x11111111..0x44444444 with ctl_rd_rdy=1 -> ctl_rd_vld rises 2 cycles after the first beat, the data appears in order, ctl_rd_last=1 only on 0x44444444, and fifo_cnt never exceeds 1.
REQ-039 ctl_rd_rdy=0 while 4 beats arrive -> fifo_cnt=4 with the head held at beat 0; a 5th beat is then dropped, ovfl_err=1, and fifo_cnt stays 4.
REQ-040 Full FIFO, a 5th beat arriving with ctl_rd_rdy=1 in the push cycle -> no drop, ovfl_err=0, and output order is 1,2,3,4,5.
REQ-041 Overflow, then two further bursts -> ctl_rd_last still marks every 4th pad beat, including counted drops.
REQ-042 rst asserted after beat 2 of a burst -> ctl_rd_vld=0 and fifo_cnt=0; the next burst gives ctl_rd_last on its 4th beat.
REQ-043 With PARITY_EN, beat 0x01030007 -> ctl_rd_par=4'b1001; without PARITY_EN, the same stimulus passes REQ-038..042 unchanged.
